// File: rtl/vrf_operand_requester.sv
// Lane VRF operand requester: turns per-queue read commands plus one write stream
// into at most one request per bank per cycle, with credit-based back-pressure per operand queue.
module vrf_operand_requester #(
  parameter int unsigned NrBanks    = 8,
  parameter int unsigned NrOpQueues = 4,
  parameter int unsigned QueueDepth = 2,
  parameter int unsigned AddrWidth  = 16,
  parameter int unsigned LenWidth   = 16,
  parameter int unsigned DataWidth  = 64,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned BankBits  = $clog2(NrBanks),
  localparam int unsigned QBits     = $clog2(NrOpQueues),
  localparam int unsigned CrdBits   = $clog2(QueueDepth + 1)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NrOpQueues-1:0]                         cmd_valid_i,
  output logic [NrOpQueues-1:0]                         cmd_ready_o,
  input  logic [NrOpQueues-1:0][AddrWidth-1:0]          cmd_addr_i,
  input  logic [NrOpQueues-1:0][LenWidth-1:0]           cmd_len_i,
  output logic [NrOpQueues-1:0]                         cmd_done_o,
  input  logic [NrOpQueues-1:0]                         credit_i,
  input  logic                                          wr_valid_i,
  output logic                                          wr_ready_o,
  input  logic [AddrWidth-1:0]                          wr_addr_i,
  input  logic [DataWidth-1:0]                          wr_data_i,
  input  logic [StrbWidth-1:0]                          wr_be_i,
  output logic [NrBanks-1:0]                            req_o,
  output logic [NrBanks-1:0][AddrWidth-BankBits-1:0]    addr_o,
  output logic [NrBanks-1:0][QBits-1:0]                 tgt_opqueue_o,
  output logic [NrBanks-1:0]                            wen_o,
  output logic [NrBanks-1:0][DataWidth-1:0]             wdata_o,
  output logic [NrBanks-1:0][StrbWidth-1:0]             be_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [NrOpQueues-1:0][0:0]           r_state;
  logic [NrOpQueues-1:0][AddrWidth-1:0] r_addr;
  logic [NrOpQueues-1:0][LenWidth-1:0]  r_remaining;
  logic [NrOpQueues-1:0][CrdBits-1:0]   r_credit;
  logic [NrOpQueues-1:0]                r_zero_done;
  logic [NrBanks-1:0][QBits-1:0]        r_rr_ptr;

  logic [NrOpQueues-1:0]                w_bid;
  logic [NrOpQueues-1:0]                w_grant;
  logic [NrBanks-1:0]                   w_rd_gnt;
  logic [NrBanks-1:0][QBits-1:0]        w_rd_win;
  logic [BankBits-1:0]                  w_wr_bank;

  assign w_wr_bank  = wr_addr_i[BankBits-1:0];
  // Every write address maps to some bank, and a write always beats reads there.
  assign wr_ready_o = wr_valid_i;

  always_comb begin
    for (int q = 0; q < NrOpQueues; q++) begin
      w_bid[q]       = (r_state[q] == ST_REQ) && (r_credit[q] != '0);
      cmd_ready_o[q] = (r_state[q] == ST_IDLE);
      cmd_done_o[q]  = (w_grant[q] && (r_remaining[q] == LenWidth'(1))) || r_zero_done[q];
    end
  end

  always_comb begin : arbiter
    logic [QBits-1:0] v_idx;
    // NOTE: every output of this block gets a default first so no latch is inferred.
    v_idx         = '0;
    req_o         = '0;
    addr_o        = '0;
    tgt_opqueue_o = '0;
    wen_o         = '0;
    wdata_o       = '0;
    be_o          = '0;
    w_grant       = '0;
    w_rd_gnt      = '0;
    w_rd_win      = '0;
    for (int b = 0; b < NrBanks; b++) begin
      if (wr_valid_i && (w_wr_bank == BankBits'(b))) begin
        req_o[b]   = 1'b1;
        wen_o[b]   = 1'b1;
        addr_o[b]  = wr_addr_i[AddrWidth-1:BankBits];
        wdata_o[b] = wr_data_i;
        be_o[b]    = wr_be_i;
      end else begin
        // Scan from the bank's pointer; first bidder targeting this bank wins.
        for (int off = 0; off < int'(NrOpQueues); off++) begin
          v_idx = QBits'((int'(r_rr_ptr[b]) + off) % int'(NrOpQueues));
          if (!w_rd_gnt[b] && w_bid[v_idx] && (r_addr[v_idx][BankBits-1:0] == BankBits'(b))) begin
            w_rd_gnt[b]      = 1'b1;
            w_rd_win[b]      = v_idx;
            w_grant[v_idx]   = 1'b1;
            req_o[b]         = 1'b1;
            addr_o[b]        = r_addr[v_idx][AddrWidth-1:BankBits];
            tgt_opqueue_o[b] = v_idx;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_zero_done <= '0;
      r_rr_ptr    <= '0;
      for (int q = 0; q < NrOpQueues; q++) r_credit[q] <= CrdBits'(QueueDepth);
    end else begin
      for (int q = 0; q < NrOpQueues; q++) begin
        r_zero_done[q] <= 1'b0;
        case (r_state[q])
          ST_IDLE: begin
            if (cmd_valid_i[q]) begin
              r_addr[q]      <= cmd_addr_i[q];
              r_remaining[q] <= cmd_len_i[q];
              if (cmd_len_i[q] == '0) r_zero_done[q] <= 1'b1;
              else                    r_state[q]     <= ST_REQ;
            end
          end
          default: begin
            if (w_grant[q]) begin
              r_addr[q]      <= r_addr[q] + AddrWidth'(1);
              r_remaining[q] <= r_remaining[q] - LenWidth'(1);
              if (r_remaining[q] == LenWidth'(1)) r_state[q] <= ST_IDLE;
            end
          end
        endcase
        r_credit[q] <= r_credit[q] - CrdBits'(w_grant[q]) + CrdBits'(credit_i[q]);
      end
      for (int b = 0; b < NrBanks; b++) begin
        if (w_rd_gnt[b]) begin
          r_rr_ptr[b] <= (w_rd_win[b] == QBits'(NrOpQueues - 1)) ? '0
                                                                : w_rd_win[b] + QBits'(1);
        end
      end
    end
  end

  for (genvar gq = 0; gq < NrOpQueues; gq++) begin : g_credit_chk
    a_no_credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(credit_i[gq] && (r_credit[gq] == CrdBits'(QueueDepth))));
  end

endmodule

// File: tb/tb_vrf_operand_requester.sv
// Directed bench for vrf_operand_requester: bank mapping, round-robin, write priority,
// credit stalls, zero-length commands, address wrap and asynchronous reset.
module tb_vrf_operand_requester;

  localparam int NB = 8;
  localparam int NQ = 4;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int BB = 3;
  localparam int QB = 2;

  logic                         clk_i;
  logic                         rst_ni;
  logic [NQ-1:0]                cmd_valid_i;
  logic [NQ-1:0]                cmd_ready_o;
  logic [NQ-1:0][AW-1:0]        cmd_addr_i;
  logic [NQ-1:0][LW-1:0]        cmd_len_i;
  logic [NQ-1:0]                cmd_done_o;
  logic [NQ-1:0]                credit_i;
  logic                         wr_valid_i;
  logic                         wr_ready_o;
  logic [AW-1:0]                wr_addr_i;
  logic [DW-1:0]                wr_data_i;
  logic [SW-1:0]                wr_be_i;
  logic [NB-1:0]                req_o;
  logic [NB-1:0][AW-BB-1:0]     addr_o;
  logic [NB-1:0][QB-1:0]        tgt_opqueue_o;
  logic [NB-1:0]                wen_o;
  logic [NB-1:0][DW-1:0]        wdata_o;
  logic [NB-1:0][SW-1:0]        be_o;

  int n_checks = 0;
  int n_fail   = 0;

  vrf_operand_requester #(
    .NrBanks(NB), .NrOpQueues(NQ), .QueueDepth(2),
    .AddrWidth(AW), .LenWidth(LW), .DataWidth(DW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_done_o(cmd_done_o),
    .credit_i(credit_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
    .req_o(req_o), .addr_o(addr_o), .tgt_opqueue_o(tgt_opqueue_o),
    .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic issue(input int q, input logic [AW-1:0] a, input logic [LW-1:0] l);
    cmd_valid_i[q] = 1'b1;
    cmd_addr_i[q]  = a;
    cmd_len_i[q]   = l;
    tick();
    cmd_valid_i[q] = 1'b0;
  endtask

  task automatic give_credit(input int q, input int n);
    for (int i = 0; i < n; i++) begin
      credit_i[q] = 1'b1;
      tick();
      credit_i[q] = 1'b0;
    end
  endtask

  initial begin
    int grants, outst, max_out, done_cnt, done_at, g;
    rst_ni      = 1'b0;
    cmd_valid_i = '0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    credit_i    = '0;
    wr_valid_i  = 1'b0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    wr_be_i     = '0;

    // Reset state
    #12;
    check("rst_ready", cmd_ready_o, 4'hF);
    check("rst_req",   req_o, 8'h00);
    check("rst_wen",   wen_o, 8'h00);
    check("rst_done",  cmd_done_o, 4'h0);
    check("rst_wrrdy", wr_ready_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Bank conflict: q0..q2 all at 0x8, len 1
    for (int q = 0; q < 3; q++) begin
      cmd_valid_i[q] = 1'b1;
      cmd_addr_i[q]  = 16'h0008;
      cmd_len_i[q]   = 16'd1;
    end
    tick();
    cmd_valid_i = '0;
    sample();
    check("cf1_req",   req_o, 8'h01);
    check("cf1_addr",  addr_o[0], 13'd1);
    check("cf1_tgt",   tgt_opqueue_o[0], 2'd0);
    check("cf1_done",  cmd_done_o, 4'b0001);
    check("cf1_ready", cmd_ready_o, 4'b1000);
    tick();
    sample();
    check("cf2_tgt",  tgt_opqueue_o[0], 2'd1);
    check("cf2_done", cmd_done_o, 4'b0010);
    tick();
    sample();
    check("cf3_tgt",  tgt_opqueue_o[0], 2'd2);
    check("cf3_done", cmd_done_o, 4'b0100);
    tick();
    // Pointer now 3: q3 must beat q0 on bank 0
    cmd_valid_i[0] = 1'b1; cmd_addr_i[0] = 16'h0000; cmd_len_i[0] = 16'd1;
    cmd_valid_i[3] = 1'b1; cmd_addr_i[3] = 16'h0000; cmd_len_i[3] = 16'd1;
    tick();
    cmd_valid_i = '0;
    sample();
    check("rr_first_tgt", tgt_opqueue_o[0], 2'd3);
    check("rr_first_done", cmd_done_o, 4'b1000);
    tick();
    sample();
    check("rr_second_tgt", tgt_opqueue_o[0], 2'd0);
    tick();
    give_credit(0, 2);
    give_credit(1, 1);
    give_credit(2, 1);
    give_credit(3, 1);

    // Single read q0, addr 0x10, len 3
    issue(0, 16'h0010, 16'd3);
    sample();
    check("sr1_req",   req_o, 8'h01);
    check("sr1_addr",  addr_o[0], 13'd2);
    check("sr1_tgt",   tgt_opqueue_o[0], 2'd0);
    check("sr1_wen",   wen_o, 8'h00);
    check("sr1_ready", cmd_ready_o[0], 1'b0);
    tick();
    sample();
    check("sr2_req",  req_o, 8'h02);
    check("sr2_addr", addr_o[1], 13'd2);
    tick();
    sample();
    check("sr_stall_req",  req_o, 8'h00);
    check("sr_stall_done", cmd_done_o, 4'h0);
    tick();
    credit_i[0] = 1'b1;
    sample();
    check("sr_crd_cycle_req", req_o, 8'h00);
    tick();
    credit_i[0] = 1'b0;
    sample();
    check("sr3_req",  req_o, 8'h04);
    check("sr3_addr", addr_o[2], 13'd2);
    check("sr3_done", cmd_done_o, 4'b0001);
    tick();
    sample();
    check("sr_end_ready", cmd_ready_o[0], 1'b1);
    check("sr_end_done",  cmd_done_o, 4'h0);
    tick();
    give_credit(0, 2);

    // Credit stall: q0 len 4, credit pulse every 3 cycles
    issue(0, 16'h0020, 16'd4);
    grants = 0; outst = 0; max_out = 0; done_cnt = 0; done_at = 0;
    for (int cyc = 0; cyc < 40 && !(grants == 4 && outst == 0); cyc++) begin
      credit_i[0] = ((cyc % 3) == 2) && (outst > 0);
      sample();
      g = (req_o != '0) ? 1 : 0;
      grants += g;
      if (cmd_done_o[0]) begin
        done_cnt++;
        done_at = grants;
      end
      outst = outst + g - int'(credit_i[0]);
      if (outst > max_out) max_out = outst;
      tick();
    end
    credit_i = '0;
    check("cs_grants",   grants, 4);
    check("cs_max_out",  max_out, 2);
    check("cs_done_cnt", done_cnt, 1);
    check("cs_done_at",  done_at, 4);
    check("cs_drained",  outst, 0);

    // Write priority on bank 1
    issue(1, 16'h0009, 16'd1);
    wr_valid_i = 1'b1;
    wr_addr_i  = 16'h0009;
    wr_data_i  = 64'hDEAD_BEEF_0123_4567;
    wr_be_i    = 8'hA5;
    sample();
    check("wp_wrrdy", wr_ready_o, 1'b1);
    check("wp_req",   req_o, 8'h02);
    check("wp_wen",   wen_o, 8'h02);
    check("wp_addr",  addr_o[1], 13'd1);
    check("wp_data",  wdata_o[1], 64'hDEAD_BEEF_0123_4567);
    check("wp_be",    be_o[1], 8'hA5);
    check("wp_tgt",   tgt_opqueue_o[1], 2'd0);
    check("wp_done",  cmd_done_o, 4'h0);
    tick();
    wr_valid_i = 1'b0;
    sample();
    check("wp_rd_req",   req_o, 8'h02);
    check("wp_rd_wen",   wen_o, 8'h00);
    check("wp_rd_tgt",   tgt_opqueue_o[1], 2'd1);
    check("wp_rd_wdata", wdata_o[1], 64'h0);
    check("wp_rd_done",  cmd_done_o, 4'b0010);
    check("wp_rd_wrrdy", wr_ready_o, 1'b0);
    tick();
    give_credit(1, 1);

    // Zero length then address wrap on q3
    cmd_valid_i[3] = 1'b1;
    cmd_addr_i[3]  = 16'h1234;
    cmd_len_i[3]   = 16'd0;
    sample();
    check("zl_ready_hs", cmd_ready_o[3], 1'b1);
    tick();
    cmd_valid_i[3] = 1'b0;
    sample();
    check("zl_done",  cmd_done_o, 4'b1000);
    check("zl_req",   req_o, 8'h00);
    check("zl_ready", cmd_ready_o[3], 1'b1);
    tick();
    sample();
    check("zl_done_once", cmd_done_o, 4'h0);
    tick();
    issue(3, 16'hFFFF, 16'd2);
    sample();
    check("wr7_req",  req_o, 8'h80);
    check("wr7_addr", addr_o[7], 13'h1FFF);
    check("wr7_tgt",  tgt_opqueue_o[7], 2'd3);
    tick();
    sample();
    check("wr0_req",  req_o, 8'h01);
    check("wr0_addr", addr_o[0], 13'd0);
    check("wr0_done", cmd_done_o, 4'b1000);
    tick();
    give_credit(3, 2);

    // Async reset mid-command with q2 credits exhausted
    issue(2, 16'h0000, 16'd5);
    sample();
    check("ar1_req", req_o, 8'h01);
    tick();
    sample();
    check("ar2_req", req_o, 8'h02);
    tick();
    sample();
    check("ar_stall_req",   req_o, 8'h00);
    check("ar_stall_ready", cmd_ready_o[2], 1'b0);
    rst_ni = 1'b0;
    #1;
    check("ar_in_ready", cmd_ready_o, 4'hF);
    check("ar_in_req",   req_o, 8'h00);
    check("ar_in_done",  cmd_done_o, 4'h0);
    tick();
    rst_ni = 1'b1;
    sample();
    check("ar_post_ready", cmd_ready_o, 4'hF);
    check("ar_post_done",  cmd_done_o, 4'h0);
    tick();
    issue(2, 16'h0000, 16'd3);
    sample();
    check("arc1_req", req_o, 8'h01);
    tick();
    sample();
    check("arc2_req", req_o, 8'h02);
    tick();
    sample();
    check("arc_stall_req", req_o, 8'h00);
    tick();
    credit_i[2] = 1'b1;
    tick();
    credit_i[2] = 1'b0;
    sample();
    check("arc3_req",  req_o, 8'h04);
    check("arc3_done", cmd_done_o, 4'b0100);
    tick();
    give_credit(2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vrf_operand_requester.md
Name: vrf_operand_requester

Overview:
- Initiator side of the lane VRF bank interface.
- Accepts per-operand-queue read commands and a single write stream from the result path.
- Converts them into one request per bank per cycle, carrying bank-local address, target operand queue, write enable, data and byte-enable.
- Per-queue credit counters ensure returned read data, valid one cycle after grant, never overflows an operand queue.

Parameters:
- NrBanks, 8, number of VRF banks; power of two, at least 2.
- NrOpQueues, 4, number of read requesters/operand queues; at least 2.
- QueueDepth, 2, entries per operand queue; initial credit value.
- AddrWidth, 16, lane word-address width.
- LenWidth, 16, command length width, in 64-bit words.
- DataWidth, 64, word width; StrbWidth = DataWidth/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  NrOpQueues  read command valid, one per queue
- cmd_ready_o  out  NrOpQueues  requester idle, accepts command
- cmd_addr_i  in  NrOpQueues x AddrWidth  start word address
- cmd_len_i  in  NrOpQueues x LenWidth  number of words to read
- cmd_done_o  out  NrOpQueues  one-cycle pulse when the last word of a command is granted
- credit_i  in  NrOpQueues  pulse: queue popped one entry
- wr_valid_i  in  1  write request valid
- wr_ready_o  out  1  write granted this cycle
- wr_addr_i  in  AddrWidth  write word address
- wr_data_i  in  DataWidth  write data
- wr_be_i  in  StrbWidth  write byte-enable
- req_o  out  NrBanks  bank request
- addr_o  out  NrBanks x (AddrWidth-log2 NrBanks)  bank-local address
- tgt_opqueue_o  out  NrBanks x log2(NrOpQueues)  read destination queue
- wen_o  out  NrBanks  write enable
- wdata_o  out  NrBanks x DataWidth  write data
- be_o  out  NrBanks x StrbWidth  byte-enable

Behaviour:
- Reset is asynchronous, active-low (rst_ni), on clock clk_i.
- Reset values: all requesters IDLE; cmd_ready_o all 1; credits = QueueDepth; req_o, wen_o, cmd_done_o, wr_ready_o all 0.
- Address mapping: bank = addr[log2 NrBanks-1:0]; addr_o = addr >> log2 NrBanks. Consecutive words rotate across banks.
- Requester FSM, one per queue:
  - IDLE: cmd_valid&cmd_ready handshake loads addr and remaining = len.
  - len=0: handshake accepted, no requests, cmd_done pulses the next cycle, stays IDLE.
  - len>0: go to REQ.
  - REQ: bids for bank(addr) only while credit>0.
  - On grant: addr+1 (wraps at 2^AddrWidth), remaining-1, credit-1.
  - Grant of the last word: cmd_done pulse in the same cycle; next state IDLE; cmd_ready_o high the following cycle.
- Credits:
  - Counter range 0..QueueDepth.
  - Same-cycle grant and credit_i: net unchanged.
  - credit_i while at QueueDepth is illegal; assert.
- Per-bank arbitration, combinational, outputs unregistered:
  - A valid write to the bank always wins; wr_ready_o=1 that cycle.
  - Otherwise round-robin among bidding read requesters.
  - Per-bank RR pointer advances to one past the winner only on a read grant.
  - At most one grant per bank per cycle; each requester bids at most one bank.
- Read request outputs: req_o=1, wen_o=0, tgt_opqueue_o=winner index; wdata_o/be_o don't-care, driven 0.
- Write request outputs: req_o=1, wen_o=1, wdata_o/be_o from the write port; tgt_opqueue_o=0.
- Idle bank: req_o=0 and all other per-bank outputs 0.
- wr_valid_i must stay stable until wr_ready_o (valid/ready). Write grant is combinational in the same cycle.
- Latency: a command accepted in cycle N issues its first request in cycle N+1 at the earliest; VRF data returns in N+2.
- Reset mid-command aborts all commands and restores credits; no done pulse.

Test Plan:
- Single read: queue0 cmd addr=0x10, len=3, no contention -> banks 0,1,2 requested in consecutive cycles, addr_o=2,2,2, tgt=0; cmd_done_o[0] with the third grant; credit ends at QueueDepth-3 clamped by stalls. With QueueDepth=2 the third request waits for credit_i.
- Credit stall: QueueDepth=2, len=4, credit_i pulses every 3 cycles -> never more than 2 outstanding; 4 grants total; done on the 4th.
- Bank conflict: queues 0,1,2 all start at addr 0x8, len=1, credits full -> bank 0 grants q0, q1, q2 in three consecutive cycles; RR pointer then at 3.
- Write priority: write to addr 0x9 held valid while q1 bids bank 1 -> write granted first (wen_o[1]=1, be passed); q1 granted the next cycle.
- Zero length and wrap: q3 len=0 -> ready held 1, done pulse, no req_o; then addr=0xFFFF, len=2 -> bank 7 then bank 0, addr_o wraps to 0.
- Async reset asserted mid-command with credits at 0 -> outputs zero immediately; after release, cmd_ready_o all 1 and credits back to QueueDepth.
